// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with optional hardwired zero
// register, same-cycle write forwarding and a sequenced bulk-clear engine.
module regfile_param #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter bit ZERO_REG0 = 1'b1,
   parameter bit FWD_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] wrReg_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rdReg_addr1,
   input  logic [ADDR_W-1:0] rdReg_addr2,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                w_idle;
   logic                w_wr_en;
   logic                w_fwd;

   assign w_idle  = (r_state == S_IDLE);
   assign w_wr_en = w_idle && regWrite && !(ZERO_REG0 && (wrReg_addr == '0));
   assign w_fwd   = FWD_EN && w_idle && regWrite;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (clr_req) w_next_state = S_CLEAR;
         S_CLEAR: if (r_idx == IDX_LAST) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Index is parked at 0 while idle, so entering CLEAR always starts at register 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_idle) begin
         r_idx <= '0;
      end else if (r_state == S_CLEAR) begin
         r_idx <= r_idx + IDX_ONE;
      end
   end

   // NOTE: the array sits in the async reset because every register must read 0 out of reset; this forces flops, not RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == S_CLEAR) begin
         r_mem[r_idx] <= '0;
      end else if (w_wr_en) begin
         r_mem[wrReg_addr] <= wr_data;
      end
   end

   // Zero register wins over forwarding, forwarding wins over the stored value.
   assign data1 = (ZERO_REG0 && (rdReg_addr1 == '0)) ? '0 :
                  (w_fwd && (rdReg_addr1 == wrReg_addr)) ? wr_data : r_mem[rdReg_addr1];
   assign data2 = (ZERO_REG0 && (rdReg_addr2 == '0)) ? '0 :
                  (w_fwd && (rdReg_addr2 == wrReg_addr)) ? wr_data : r_mem[rdReg_addr2];

   assign clr_busy = (r_state != S_IDLE);
   assign clr_done = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: two instances (zero-reg+forwarding,
// and neither) driven by shared stimulus and compared against a behavioural model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        regWrite;
   logic [3:0]  wrReg_addr;
   logic [15:0] wr_data;
   logic [3:0]  rdReg_addr1;
   logic [3:0]  rdReg_addr2;
   logic        clr_req;

   logic [15:0] d1_a, d2_a, d1_b, d2_b;
   logic        busy_a, done_a, busy_b, done_b;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Model: per-instance register contents plus clear position
   // (-1 idle, 0..15 register being cleared next, 16 done cycle).
   logic [15:0] m_mem [2][16];
   int          m_pos = -1;

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1'b1), .FWD_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wrReg_addr(wrReg_addr),
      .wr_data(wr_data), .rdReg_addr1(rdReg_addr1), .rdReg_addr2(rdReg_addr2),
      .data1(d1_a), .data2(d2_a), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
   );

   regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1'b0), .FWD_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .wrReg_addr(wrReg_addr),
      .wr_data(wr_data), .rdReg_addr1(rdReg_addr1), .rdReg_addr2(rdReg_addr2),
      .data1(d1_b), .data2(d2_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Instance 0 has hardwired zero and forwarding; instance 1 has neither.
   function automatic logic [15:0] exp_rd(input int k, input logic [3:0] a);
      if (k == 0 && a == 4'd0) return 16'h0000;
      if (k == 0 && m_pos == -1 && regWrite && a == wrReg_addr) return wr_data;
      return m_mem[k][a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) m_mem[k][a] = 16'h0000;
         m_pos = -1;
      end else if (m_pos == -1) begin
         if (regWrite) begin
            if (wrReg_addr != 4'd0) m_mem[0][wrReg_addr] = wr_data;
            m_mem[1][wrReg_addr] = wr_data;
         end
         if (clr_req) m_pos = 0;
      end else if (m_pos < 16) begin
         m_mem[0][m_pos] = 16'h0000;
         m_mem[1][m_pos] = 16'h0000;
         m_pos++;
      end else begin
         m_pos = -1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_d1_a", d1_a, exp_rd(0, rdReg_addr1));
         check("cmp_d2_a", d2_a, exp_rd(0, rdReg_addr2));
         check("cmp_d1_b", d1_b, exp_rd(1, rdReg_addr1));
         check("cmp_d2_b", d2_b, exp_rd(1, rdReg_addr2));
         check("cmp_busy_a", 16'(busy_a), 16'(m_pos != -1));
         check("cmp_done_a", 16'(done_a), 16'(m_pos == 16));
         check("cmp_busy_b", 16'(busy_b), 16'(m_pos != -1));
         check("cmp_done_b", 16'(done_b), 16'(m_pos == 16));
      end
   end

   task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] a1, input logic [3:0] a2, input logic req);
      @(posedge clk);
      #2;
      regWrite    = we;
      wrReg_addr  = wa;
      wr_data     = wd;
      rdReg_addr1 = a1;
      rdReg_addr2 = a2;
      clr_req     = req;
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      rst_n = 1'b0;
      regWrite = 1'b0; wrReg_addr = 4'd0; wr_data = 16'h0000;
      rdReg_addr1 = 4'd0; rdReg_addr2 = 4'd0; clr_req = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state
      step(1'b0, 4'd0, 16'h0000, 4'd2, 4'd15, 1'b0);
      check("rst_d1", d1_a, 16'h0000);
      check("rst_d2", d2_a, 16'h0000);
      check("rst_busy", 16'(busy_a), 16'h0000);
      check("rst_done", 16'(done_a), 16'h0000);

      // Forwarding vs. no forwarding
      step(1'b1, 4'd2, 16'd69, 4'd2, 4'd2, 1'b0);
      check("fwd_on_same", d1_a, 16'd69);
      check("fwd_off_same", d1_b, 16'h0000);
      step(1'b0, 4'd0, 16'h0000, 4'd2, 4'd2, 1'b0);
      check("fwd_on_next", d1_a, 16'd69);
      check("fwd_off_next", d1_b, 16'd69);

      // Register 0 behaviour
      step(1'b1, 4'd0, 16'hBEEF, 4'd0, 4'd0, 1'b0);
      check("zero_same", d1_a, 16'h0000);
      check("nozero_same", d1_b, 16'h0000);
      step(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
      check("zero_next", d1_a, 16'h0000);
      check("nozero_next", d1_b, 16'hBEEF);

      // Fill 1..15 with addr*3
      for (int a = 1; a < 16; a++) step(1'b1, 4'(a), 16'(a * 3), 4'(a), 4'd0, 1'b0);
      step(1'b0, 4'd0, 16'h0000, 4'd4, 4'd7, 1'b0);
      check("fill_r4", d1_a, 16'd12);
      check("fill_r7", d2_b, 16'd21);

      // clr_req with a same-cycle write that must still commit
      step(1'b1, 4'd9, 16'h0055, 4'd9, 4'd0, 1'b1);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(i == 3, 4'd5, 16'h1234, 4'd9, 4'd5, 1'b0);
         if (i == 0) check("req_cycle_write", d1_a, 16'h0055);
         if (i == 3) check("clear_no_fwd", d2_a, 16'd15);
         if (busy_a) busy_cnt++;
         if (done_a) done_cnt++;
         if (!busy_a) break;
      end
      check("busy_cycles", 16'(busy_cnt), 16'd17);
      check("done_cycles", 16'(done_cnt), 16'd1);
      for (int a = 0; a < 16; a++) begin
         step(1'b0, 4'd0, 16'h0000, 4'(a), 4'(a), 1'b0);
         check("cleared_a", d1_a, 16'h0000);
         check("cleared_b", d2_b, 16'h0000);
      end
      step(1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 1'b0);
      check("dropped_write_r5", d1_b, 16'h0000);

      // Reset in the middle of a clear
      for (int a = 1; a < 16; a++) step(1'b1, 4'(a), 16'(a + 100), 4'(a), 4'd0, 1'b0);
      step(1'b0, 4'd0, 16'h0000, 4'd12, 4'd0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 16'h0000, 4'd12, 4'd3, 1'b0);
      check("midclr_busy_pre", 16'(busy_a), 16'h0001);
      @(posedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_busy", 16'(busy_a), 16'h0000);
         check("midrst_done", 16'(done_a), 16'h0000);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         step(1'b0, 4'd0, 16'h0000, 4'(a), 4'(a), 1'b0);
         check("midrst_done_after", 16'(done_b), 16'h0000);
         check("midrst_reg", d2_b, 16'h0000);
      end
      step(1'b1, 4'd3, 16'h00AA, 4'd0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 1'b0);
      check("post_rst_write", d1_a, 16'h00AA);
      check("post_rst_write_b", d2_b, 16'h00AA);

      // Randomised traffic, checked every cycle by the compare process
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 40) == 0));
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
